// File: rtl/counter_pkg.sv
// Shared definitions for the programmable interval counter: FSM state encoding
// and the default counter width.
package counter_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : counter_pkg

// File: rtl/counter_ctrl_if.sv
// Host-side control/status bundle for counter_ctrl: configuration, run control
// and the registered count/status outputs.
interface counter_ctrl_if
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             cfg_we;
    logic [WIDTH-1:0] cfg_term;
    logic             cfg_auto;
    logic             start;
    logic             stop;
    logic             hold;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       state;

    modport master (
        output cfg_we, cfg_term, cfg_auto, start, stop, hold,
        input  value, busy, done, err, state
    );

    modport slave (
        input  cfg_we, cfg_term, cfg_auto, start, stop, hold,
        output value, busy, done, err, state
    );

endinterface : counter_ctrl_if

// File: rtl/counter_core.sv
// Count value register: asynchronous reset, synchronous clear (priority) and
// increment enable, wrapping modulo 2^WIDTH.
module counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (en_i) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule : counter_core

// File: rtl/counter_ctrl.sv
// Interval counter sequencer: start/stop/hold FSM, terminal-count detection
// with optional auto-reload, driving the counter_core value register.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    counter_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] term_q,  term_d;
    logic             auto_q,  auto_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;
    logic             clr;
    logic             en;
    logic [WIDTH-1:0] value_w;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr),
        .en_i    (en),
        .value_o (value_w)
    );

    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        auto_d  = auto_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;

        // Configuration may only change while the counter is not running.
        if (bus.cfg_we) begin
            if (state_q == IDLE || state_q == DONE) begin
                term_d = bus.cfg_term;
                auto_d = bus.cfg_auto;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start && !bus.stop) begin
                    clr     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.hold) begin
                    state_d = HOLD;
                end else if (value_w == term_q) begin
                    done_d = 1'b1;
                    if (auto_q) begin
                        clr = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    en = 1'b1;
                end
            end
            HOLD: begin
                // Leaving HOLD spends one edge without counting.
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (!bus.hold) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            term_q  <= '0;
            auto_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            auto_q  <= auto_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.value = value_w;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.state = state_q;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: a vector table for the basic and auto-reload
// runs, followed by hand-written hold/stop, rejection, term edge and reset sequences.
module tb_counter_ctrl;

    localparam int W = 8;

    typedef struct {
        logic         cfg_we;
        logic [W-1:0] term;
        logic         aut;
        logic         start;
        logic         stop;
        logic         hold;
        logic [W-1:0] ev;
        logic         eb;
        logic         ed;
        logic         ee;
        logic [1:0]   es;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    counter_ctrl_if #(.WIDTH(W)) bus ();

    counter_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int v, input int b, input int d,
                             input int e, input int s);
        check({tag, ".value"}, int'(bus.value), v);
        check({tag, ".busy"},  int'(bus.busy),  b);
        check({tag, ".done"},  int'(bus.done),  d);
        check({tag, ".err"},   int'(bus.err),   e);
        check({tag, ".state"}, int'(bus.state), s);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [W-1:0] t, input logic a,
                         input logic s, input logic p, input logic h);
        bus.cfg_we   = we;
        bus.cfg_term = t;
        bus.cfg_auto = a;
        bus.start    = s;
        bus.stop     = p;
        bus.hold     = h;
    endtask

    task automatic add(input logic we, input int t, input logic a, input logic s,
                       input logic p, input logic h, input int ev, input logic eb,
                       input logic ed, input logic ee, input int es);
        vec_t r;
        r.cfg_we = we; r.term = W'(t); r.aut = a;
        r.start = s; r.stop = p; r.hold = h;
        r.ev = W'(ev); r.eb = eb; r.ed = ed; r.ee = ee; r.es = 2'(es);
        tbl.push_back(r);
    endtask

    task automatic wait_value(input string name, input int v, input int limit);
        int n = 0;
        while (int'(bus.value) != v && n < limit) begin
            step();
            n++;
        end
        check(name, int'(bus.value), v);
    endtask

    initial begin
        int n;

        //  we term a  st sp ho | val busy done err state
        add(1, 5,  0, 0, 0, 0,   0,  0,   0,   0,  0);
        add(0, 0,  0, 1, 0, 0,   0,  1,   0,   0,  1);
        add(0, 0,  0, 0, 0, 0,   1,  1,   0,   0,  1);
        add(0, 0,  0, 0, 0, 0,   2,  1,   0,   0,  1);
        add(0, 0,  0, 0, 0, 0,   3,  1,   0,   0,  1);
        add(0, 0,  0, 0, 0, 0,   4,  1,   0,   0,  1);
        add(0, 0,  0, 0, 0, 0,   5,  1,   0,   0,  1);
        add(0, 0,  0, 0, 0, 0,   5,  0,   1,   0,  3);
        add(0, 0,  0, 0, 0, 0,   5,  0,   0,   0,  3);
        add(1, 3,  1, 0, 0, 0,   5,  0,   0,   0,  3);
        add(0, 0,  0, 1, 0, 0,   0,  1,   0,   0,  1);
        for (int k = 0; k < 2; k++) begin
            add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
            add(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1);
            add(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
            add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        end
        add(0, 0,  0, 0, 0, 0,   1,  1,   0,   0,  1);
        add(0, 0,  0, 0, 1, 0,   1,  0,   0,   0,  0);
        add(0, 0,  0, 1, 1, 0,   1,  0,   0,   0,  0);

        drive(0, '0, 0, 0, 0, 0);
        #17 reset = 1'b1;
        #3 check_all("reset", 0, 0, 0, 0, 0);
        #8 reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].cfg_we, tbl[i].term, tbl[i].aut, tbl[i].start, tbl[i].stop, tbl[i].hold);
            step();
            check_all($sformatf("vec%0d", i), int'(tbl[i].ev), int'(tbl[i].eb),
                      int'(tbl[i].ed), int'(tbl[i].ee), int'(tbl[i].es));
        end
        drive(0, '0, 0, 0, 0, 0);

        // Hold for three cycles at value 4, then stop at 6.
        drive(1, 8'd10, 0, 0, 0, 0); step();
        drive(0, '0, 0, 1, 0, 0);    step();
        check_all("hs_start", 0, 1, 0, 0, 1);
        drive(0, '0, 0, 0, 0, 0);
        wait_value("hs_wait4", 4, 20);
        drive(0, '0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_all($sformatf("hold%0d", k), 4, 1, 0, 0, 2);
        end
        drive(0, '0, 0, 0, 0, 0);
        step(); check_all("hold_exit", 4, 1, 0, 0, 1);
        step(); check_all("resume5",   5, 1, 0, 0, 1);
        step(); check_all("resume6",   6, 1, 0, 0, 1);
        drive(0, '0, 0, 0, 1, 0);
        step(); check_all("stop6",     6, 0, 0, 0, 0);

        // Reconfiguration attempt while running must be rejected.
        drive(0, '0, 0, 1, 0, 0); step();
        check_all("rj_start", 0, 1, 0, 0, 1);
        drive(1, 8'd9, 0, 0, 0, 0); step();
        check_all("rj_err", 1, 1, 0, 1, 1);
        drive(0, '0, 0, 0, 0, 0); step();
        check_all("rj_err_clr", 2, 1, 0, 0, 1);
        wait_value("rj_wait9", 9, 20);
        check("rj_nodone9", int'(bus.done), 0);
        step(); check_all("rj_ten", 10, 1, 0, 0, 1);
        step(); check_all("rj_done", 10, 0, 1, 0, 3);

        // Start together with stop is ignored.
        drive(0, '0, 0, 1, 1, 0); step();
        check_all("st_sp_done", 10, 0, 0, 0, 3);

        // term=0: done one cycle after entering RUN.
        drive(1, 8'd0, 0, 0, 0, 0); step();
        drive(0, '0, 0, 1, 0, 0);   step();
        check_all("t0_run", 0, 1, 0, 0, 1);
        drive(0, '0, 0, 0, 0, 0);   step();
        check_all("t0_done", 0, 0, 1, 0, 3);

        // Full range: 255 reached without wrapping, done 256 cycles after RUN entry.
        drive(1, 8'd255, 0, 0, 0, 0); step();
        drive(0, '0, 0, 1, 0, 0);     step();
        drive(0, '0, 0, 0, 0, 0);
        n = 0;
        while (!bus.done && n < 300) begin
            step();
            n++;
        end
        check("full_cycles", n, 256);
        check_all("full_done", 255, 0, 1, 0, 3);

        // Asynchronous reset in the middle of a run.
        drive(1, 8'd5, 0, 0, 0, 0); step();
        drive(0, '0, 0, 1, 0, 0);   step();
        drive(0, '0, 0, 0, 0, 0);
        wait_value("rst_wait3", 3, 20);
        #2 reset = 1'b1;
        #1 check_all("rst_mid", 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        drive(0, '0, 0, 1, 0, 0); step();
        check_all("rst_restart", 0, 1, 0, 0, 1);
        drive(0, '0, 0, 0, 0, 0); step();
        check_all("rst_term0", 0, 0, 1, 0, 3);
        step();
        check_all("rst_after", 0, 0, 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_ctrl

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencing controller for the design's free-running up-counter datapath. Converts it into a programmable interval counter with start/stop/hold control, terminal-count detection and optional auto-reload.
- Sits between the control logic or host register interface and the counter value register.
- Exposes the live count plus a one-cycle done pulse for the rest of the pipeline.

Parameters:
- WIDTH, 8: counter and terminal-value width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_we  input  1  configuration write strobe.
- cfg_term  input  WIDTH  terminal count value; captured on cfg_we.
- cfg_auto  input  1  auto-reload enable; captured on cfg_we.
- start  input  1  start request (pulse or level; sampled each cycle).
- stop  input  1  abort request.
- hold  input  1  level; freezes counting while high.
- value  output  WIDTH  current count.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse on terminal count.
- err  output  1  one-cycle pulse when cfg_we is rejected.
- state  output  2  current FSM state, for debug.

Behaviour:
- Fixed decision: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: value=0, busy=0, done=0, err=0, state=IDLE, term register=0, auto register=0. Reset applies immediately at any point, including mid-count. No done pulse is generated by reset.
- All outputs are registered. Every transition and increment takes effect at the clk edge after the inputs are sampled.
- States: IDLE=0, RUN=1, HOLD=2, DONE=3.
- Configuration:
  - cfg_we is accepted only in IDLE or DONE; the term and auto registers update at the next edge.
  - cfg_we in RUN or HOLD is ignored and err pulses for 1 cycle.
- IDLE/DONE:
  - start=1 and stop=0: value<=0, next state RUN, busy=1 from the next cycle.
  - start and stop in the same cycle: stop wins, state unchanged.
  - value retains its last count.
- RUN, evaluated in priority order:
  1. stop: next state IDLE, value frozen, no done.
  2. hold: next state HOLD, value unchanged.
  3. value==term: done<=1 for exactly one cycle. If auto=1, value<=0 and stay in RUN. If auto=0, next state DONE, value stays at term, busy<=0.
  4. Otherwise: value<=value+1, modulo 2^WIDTH.
- HOLD:
  - stop: next state IDLE.
  - hold=0: next state RUN. No increment occurs on the exit edge; counting resumes on the following cycle.
  - hold=1: remain in HOLD.
- start while in RUN or HOLD is ignored.
- Edge cases:
  - term=0: the first RUN cycle already satisfies the terminal condition, so done pulses 1 cycle after entering RUN.
  - term=2^WIDTH-1: counts the full range without wrapping before done.
- Latency and period:
  - From the start edge to done, with no hold: term+1 cycles.
  - Auto-reload period: term+1 cycles.
- done and err never assert in the same cycle as reset.

Decomposition:
- Package counter_pkg: state encoding constants (IDLE, RUN, HOLD, DONE) and the default WIDTH.
- One sub-module, counter_core: WIDTH-bit value register with asynchronous reset, synchronous clear and enable. counter_ctrl drives its clear/enable and performs the term comparison.

Test Plan:
- Basic count: reset 17–28 ns, cfg_we with term=5 and auto=0, then a start pulse -> value steps 0..5, done pulses for 1 cycle as value reaches 5, state=DONE, busy=0, value held at 5.
- Auto-reload: term=3, auto=1, start -> value repeats 0,1,2,3,0,1..., done pulses every 4 cycles, busy stays 1.
- Hold/stop: term=10, start, hold high for 3 cycles when value=4 -> value stays 4 through HOLD plus the exit edge, then 5,6. Stop at value=6 -> IDLE, value=6, no done.
- Config rejection and simultaneous events: cfg_we term=9 during RUN -> err pulses, term stays unchanged. Start and stop in the same IDLE cycle -> stays IDLE. term=0 start -> done 1 cycle after RUN entry.
- Reset mid-operation: assert reset at value=3 in RUN -> value=0, state=IDLE, busy=0 immediately, no done. Release, then start -> counting restarts normally with term=0 (reset default).
